// File: rtl/otuziki_pkg.sv
// Shared definitions for the otuziki 1:2 operand demux router.
//   DATA_W : default word width of the routed stream
//   CNT_W  : default width of the per-channel accepted-word counters
//   SEL_A / SEL_B : route-select encodings (same polarity as the ALU 2:1 mux 'en')
//   occ_e  : occupancy state of a 2-entry channel FIFO
`timescale 1ns/1ps
package otuziki_pkg;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 16;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

endpackage

// File: rtl/chan_fifo2.sv
// Two-entry, order-preserving channel FIFO used for each router output.
// Ports:
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   push       : write data_in this cycle (ignored when full)
//   pop        : remove the head word this cycle (ignored when empty)
//   data_in    : word to write
//   head       : current head word, zero when empty
//   valid      : at least one word held
//   full       : two words held
// The occupancy register 'occ' is the FIFO's state and can be probed
// hierarchically (u_fifo_x.occ).
`timescale 1ns/1ps
module chan_fifo2
    import otuziki_pkg::*;
#(
    parameter int W = DATA_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] data_in,
    output logic [W-1:0] head,
    output logic         valid,
    output logic         full
);

    occ_e         occ;
    occ_e         occ_nx;
    logic [W-1:0] mem0;     // head slot
    logic [W-1:0] mem1;     // second slot, kept at zero when unused
    logic [W-1:0] mem0_nx;
    logic [W-1:0] mem1_nx;
    logic         do_push;
    logic         do_pop;

    assign do_pop  = pop  && (occ != OCC_EMPTY);
    assign do_push = push && (occ != OCC_FULL);

    always_comb begin
        occ_nx  = occ;
        mem0_nx = mem0;
        mem1_nx = mem1;
        case ({do_push, do_pop})
            2'b10: begin
                case (occ)
                    OCC_EMPTY: begin
                        mem0_nx = data_in;
                        occ_nx  = OCC_ONE;
                    end
                    OCC_ONE: begin
                        mem1_nx = data_in;
                        occ_nx  = OCC_FULL;
                    end
                    default: ;
                endcase
            end
            2'b01: begin
                // Shift up; an emptied slot reads back as zero.
                mem0_nx = mem1;
                mem1_nx = '0;
                occ_nx  = (occ == OCC_FULL) ? OCC_ONE : OCC_EMPTY;
            end
            2'b11: begin
                // Only reachable at occupancy 1 (push needs !full, pop needs
                // !empty): the incoming word replaces the departing head.
                mem0_nx = data_in;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ  <= OCC_EMPTY;
            mem0 <= '0;
            mem1 <= '0;
        end else begin
            occ  <= occ_nx;
            mem0 <= mem0_nx;
            mem1 <= mem1_nx;
        end
    end

    assign head  = mem0;
    assign valid = (occ != OCC_EMPTY);
    assign full  = (occ == OCC_FULL);

endmodule

// File: rtl/otuziki_demux_router.sv
// Registered 1:2 demux: routes one valid/ready word stream onto channels A
// and B, each behind its own 2-entry FIFO, and counts words accepted per
// channel.
// Handshake: every stream transfers on a rising edge where valid && ready.
// Ready is never a function of the same channel's consumer ready, so a
// full channel stays closed even while it is being popped.
// Ports:
//   clk, rst_n         : rising-edge clock, asynchronous active-low reset
//   s_data/s_sel       : input word and route select (0 -> A, 1 -> B)
//   s_valid/s_ready    : input handshake; s_ready is low during reset
//   a_data/a_valid/a_ready : channel A head word and handshake
//   b_data/b_valid/b_ready : channel B head word and handshake
//   a_count/b_count    : words accepted into each channel, modulo 2^CW
`timescale 1ns/1ps
module otuziki_demux_router
    import otuziki_pkg::*;
#(
    parameter int W  = DATA_W,
    parameter int CW = CNT_W
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [W-1:0]  s_data,
    input  logic          s_sel,
    input  logic          s_valid,
    output logic          s_ready,
    output logic [W-1:0]  a_data,
    output logic          a_valid,
    input  logic          a_ready,
    output logic [W-1:0]  b_data,
    output logic          b_valid,
    input  logic          b_ready,
    output logic [CW-1:0] a_count,
    output logic [CW-1:0] b_count
);

    logic          a_full;
    logic          b_full;
    logic          push_a;
    logic          push_b;
    logic [CW-1:0] a_cnt_q;
    logic [CW-1:0] b_cnt_q;

    // Ready depends only on the selected channel's fullness, so a full
    // channel never blocks words addressed to the other one.
    assign s_ready = rst_n && ((s_sel == SEL_B) ? !b_full : !a_full);
    assign push_a  = s_valid && s_ready && (s_sel == SEL_A);
    assign push_b  = s_valid && s_ready && (s_sel == SEL_B);

    chan_fifo2 #(.W(W)) u_fifo_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push_a),
        .pop     (a_ready),
        .data_in (s_data),
        .head    (a_data),
        .valid   (a_valid),
        .full    (a_full)
    );

    chan_fifo2 #(.W(W)) u_fifo_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push_b),
        .pop     (b_ready),
        .data_in (s_data),
        .head    (b_data),
        .valid   (b_valid),
        .full    (b_full)
    );

    // Free-running wrap at 2^CW.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_cnt_q <= '0;
            b_cnt_q <= '0;
        end else begin
            if (push_a) a_cnt_q <= a_cnt_q + 1'b1;
            if (push_b) b_cnt_q <= b_cnt_q + 1'b1;
        end
    end

    assign a_count = a_cnt_q;
    assign b_count = b_cnt_q;

endmodule

// File: tb/tb_otuziki_demux_router.sv
`timescale 1ns/1ps
module tb_otuziki_demux_router;
    import otuziki_pkg::*;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] s_data;
    logic        s_sel;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] a_data;
    logic        a_valid;
    logic        a_ready;
    logic [31:0] b_data;
    logic        b_valid;
    logic        b_ready;
    logic [15:0] a_count;
    logic [15:0] b_count;

    otuziki_demux_router dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_data  (s_data),
        .s_sel   (s_sel),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .a_data  (a_data),
        .a_valid (a_valid),
        .a_ready (a_ready),
        .b_data  (b_data),
        .b_valid (b_valid),
        .b_ready (b_ready),
        .a_count (a_count),
        .b_count (b_count)
    );

    // ---------------- reference model / scoreboard ----------------
    // Each queue is the ordered content of a channel FIFO as seen after the
    // most recent clock edge; counters are the accepted-word totals.
    logic [31:0] exp_a[$];
    logic [31:0] exp_b[$];
    logic [15:0] cnt_a;
    logic [15:0] cnt_b;
    int          checks = 0;
    int          passed = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endfunction

    function automatic void model_push(logic sel, logic [31:0] d);
        if (sel) begin
            exp_b.push_back(d);
            cnt_b = cnt_b + 16'd1;
        end else begin
            exp_a.push_back(d);
            cnt_a = cnt_a + 16'd1;
        end
    endfunction

    // Monitor: compares the DUT against the model on every falling edge,
    // then retires head words that the upcoming rising edge will pop.
    always @(negedge clk) begin : monitor
        logic        exp_rdy;
        logic [31:0] exp_ad;
        logic [31:0] exp_bd;
        exp_rdy = rst_n && (s_sel ? (exp_b.size() < 2) : (exp_a.size() < 2));
        exp_ad  = (exp_a.size() != 0) ? exp_a[0] : 32'd0;
        exp_bd  = (exp_b.size() != 0) ? exp_b[0] : 32'd0;
        check("s_ready", {31'd0, s_ready}, {31'd0, exp_rdy});
        check("a_valid", {31'd0, a_valid}, {31'd0, exp_a.size() != 0});
        check("b_valid", {31'd0, b_valid}, {31'd0, exp_b.size() != 0});
        check("a_data",  a_data, exp_ad);
        check("b_data",  b_data, exp_bd);
        check("a_count", {16'd0, a_count}, {16'd0, cnt_a});
        check("b_count", {16'd0, b_count}, {16'd0, cnt_b});
        if (rst_n && a_ready && exp_a.size() != 0) void'(exp_a.pop_front());
        if (rst_n && b_ready && exp_b.size() != 0) void'(exp_b.pop_front());
    end

    // ---------------- driver tasks ----------------
    // All drivers are entered and leave at 1 ns after a rising edge.
    task automatic send(input logic sel, input logic [31:0] d);
        int waited;
        waited  = 0;
        s_sel   = sel;
        s_data  = d;
        s_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (s_ready) begin
                @(posedge clk);
                model_push(sel, d);
                break;
            end
            @(posedge clk);
            waited++;
            if (waited > 200) begin
                check("send_timeout", 32'd0, 32'd1);
                break;
            end
        end
        #1;
        s_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        s_valid = 1'b0;
        exp_a.delete();
        exp_b.delete();
        cnt_a = 16'd0;
        cnt_b = 16'd0;
        #1;
        check("rst_s_ready", {31'd0, s_ready}, 32'd0);
        check("rst_a_valid", {31'd0, a_valid}, 32'd0);
        check("rst_a_count", {16'd0, a_count}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin : main
        logic [15:0] b_saved;
        int          n;
        s_data  = '0;
        s_sel   = 1'b0;
        s_valid = 1'b0;
        a_ready = 1'b0;
        b_ready = 1'b0;
        cnt_a   = 16'd0;
        cnt_b   = 16'd0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1);

        // Reset mid-stream
        send(SEL_A, 32'hAAAA0001);
        send(SEL_A, 32'hAAAA0002);
        do_reset();
        idle(1);

        // Basic routing and one-cycle latency
        a_ready = 1'b1;
        b_ready = 1'b1;
        send(SEL_A, 32'hDEADBEEF);
        check("lat_a_data",  a_data, 32'hDEADBEEF);
        check("lat_a_valid", {31'd0, a_valid}, 32'd1);
        send(SEL_B, 32'h12345678);
        check("lat_b_data",  b_data, 32'h12345678);
        check("cnt_a_1", {16'd0, a_count}, 32'd1);
        check("cnt_b_1", {16'd0, b_count}, 32'd1);
        idle(2);

        // Full stall on A, B still open
        a_ready = 1'b0;
        b_ready = 1'b0;
        send(SEL_A, 32'h1);
        send(SEL_A, 32'h2);
        s_sel   = SEL_A;
        s_data  = 32'h3;
        s_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("stall_a_ready", {31'd0, s_ready}, 32'd0);
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        send(SEL_B, 32'h55);
        check("stall_b_push", b_data, 32'h55);
        a_ready = 1'b1;
        b_ready = 1'b1;
        send(SEL_A, 32'h3);
        idle(4);

        // Simultaneous push/pop at occupancy 1
        a_ready = 1'b0;
        send(SEL_A, 32'hA);
        a_ready = 1'b1;
        send(SEL_A, 32'hB);
        a_ready = 1'b0;
        check("pp_a_data",  a_data, 32'hB);
        check("pp_a_valid", {31'd0, a_valid}, 32'd1);
        idle(2);
        a_ready = 1'b1;
        idle(2);

        // Full with pop: no pass-through
        a_ready = 1'b0;
        send(SEL_A, 32'h10);
        send(SEL_A, 32'h20);
        a_ready = 1'b1;
        s_sel   = SEL_A;
        s_data  = 32'h30;
        s_valid = 1'b1;
        @(negedge clk);
        check("fullpop_ready", {31'd0, s_ready}, 32'd0);
        @(posedge clk);
        #1;
        check("fullpop_head", a_data, 32'h20);
        send(SEL_A, 32'h30);
        idle(4);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            logic sel;
            a_ready = 1'($urandom_range(0, 1));
            b_ready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) < 6) begin
                sel = 1'($urandom_range(0, 1));
                if (sel && exp_b.size() >= 2) b_ready = 1'b1;
                if (!sel && exp_a.size() >= 2) a_ready = 1'b1;
                send(sel, $urandom);
            end else begin
                idle(1);
            end
        end
        a_ready = 1'b1;
        b_ready = 1'b1;
        idle(4);

        // Counter wrap on A, B untouched
        b_saved = cnt_b;
        n = 32'hFFFF - {16'd0, cnt_a};
        for (int i = 0; i < n; i++) send(SEL_A, $urandom);
        check("wrap_pre",  {16'd0, a_count}, 32'h0000FFFF);
        send(SEL_A, 32'hC0FFEE00);
        check("wrap_a",    {16'd0, a_count}, 32'h00000000);
        check("wrap_b",    {16'd0, b_count}, {16'd0, b_saved});
        idle(4);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
